mux_n_stream: RTL and testbench
===============================

// Module: mux_n_stream
// PURPOSE
//  - Parametrised N-input, WIDTH-bit stream multiplexer with registered output and valid/ready handshake.
//  - Generalises the 4:1 single-bit mux: adds width, channel count, back-pressure and an arbitration mode.
//  - Modes: fixed-select (channel given by sel) or round-robin.
//  - Sits between N producer streams and one consumer; typical use is funnelling lab peripherals into one bus.
// PARAMETERS
//  - WIDTH  default 8   data bits per channel
//  - N      default 4   number of input channels, N >= 2
//  - SELW   default $clog2(N)   select/channel-index width (derived; do not override)
// PORTS
//  - clk        in   1         rising-edge clock; the single clock of the block
//  - rst_n      in   1         asynchronous, active-low reset
//  - in_data    in   N*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//  - in_valid   in   N         channel i offers a word
//  - in_ready   out  N         channel i word accepted this cycle (valid & ready = transfer)
//  - mode       in   1         0 = MODE_FIXED (use sel), 1 = MODE_RR (round-robin)
//  - sel        in   SELW      channel index in MODE_FIXED; ignored in MODE_RR
//  - out_data   out  WIDTH     registered output word
//  - out_chan   out  SELW      source channel of out_data
//  - out_valid  out  1         out_data/out_chan hold a word
//  - out_ready  in   1         consumer accepts; transfer when out_valid & out_ready
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, last_grant=N-1.
//  - Combinational signals:
//    - load_en = !out_valid | out_ready.
//    - grant is selected per mode; gvalid is set when a grant exists.
//  - MODE_FIXED: grant=sel; gvalid = (sel < N) & in_valid[sel].
//    - sel >= N (non-power-of-2 N) never grants.
//  - MODE_RR: scan from last_grant+1 upward, mod N; the first asserted in_valid wins.
//  - in_ready[i] = load_en & gvalid & (grant==i); at most one bit is set.
//    - in_ready may depend on in_valid, but not the reverse.
//  - On clk edge:
//    - load_en & gvalid: load out_data/out_chan from the granted channel; out_valid=1.
//      - Update last_grant=grant in both modes.
//    - else if out_ready: out_valid=0; out_data/out_chan hold their value.
//    - else: hold everything.
//  - Latency: 1 cycle from input transfer to out_valid.
//  - Throughput: 1 word/cycle; pop and push in the same cycle are allowed.
//  - Held word is stable while out_valid & !out_ready.
//    - Changes on sel, mode or in_* do not affect it.
//  - mode/sel changes apply to the next grant only; no word is dropped or duplicated.
//  - Wrap-around: RR index wraps from N-1 to 0.
//    - With a single requester, it is granted every cycle it is valid.
//  - No requesters: no grant; last_grant unchanged.
//  - Reset mid-operation: the held word is discarded; out_valid drops immediately on rst_n=0.
// STRUCTURE
//  - Package mux_pkg holds:
//    - localparams MODE_FIXED=1'b0, MODE_RR=1'b1
//    - function clog2 for SELW
//  - Sub-module rr_pick #(N,SELW): combinational.
//    - Inputs: req[N], last[SELW].
//    - Outputs: idx[SELW], found.
//    - Rotate-priority scan.
//  - Top module: mode mux on grant, output register, last_grant register.
// TESTING (WIDTH=8, N=4 unless noted)
//  - Fixed sweep:
//    - Stimulus: mode=0, in_data={8'h44,8'h33,8'h22,8'h11}, all valid, out_ready=1, sel=0,1,2,3.
//    - Response: out_data 11,22,33,44 each one cycle later; out_chan=sel; in_ready one-hot on sel.
//  - Back-pressure:
//    - Stimulus: out_ready=0 after the first load; change sel and in_data for 5 cycles.
//    - Response: out_data/out_chan frozen; in_ready=0; on out_ready=1, a new word loads the same cycle as the pop.
//  - Round-robin fairness:
//    - Stimulus: mode=1, all four valid for 8 cycles, out_ready=1.
//    - Response: out_chan sequence 0,1,2,3,0,1,2,3.
//    - Stimulus: drop in_valid[1].
//    - Response: sequence 0,2,3,0.
//  - Sparse RR:
//    - Stimulus: only in_valid[3] set.
//    - Response: channel 3 granted every cycle; after wrap, channel 0 becomes valid and wins the next grant.
//  - Async reset:
//    - Stimulus: assert rst_n=0 mid-stream between clock edges.
//    - Response: out_valid=0, out_data=0, out_chan=0 immediately; first RR grant after release is channel 0.
//  - Edge select:
//    - Stimulus: N=3, mode=0, sel=2'b11, all valid.
//    - Response: no in_ready asserted; out_valid stays 0.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the mux_n_stream block.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input
//   clog2()              : ceiling log2, used to size channel-index fields
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2 for v >= 2 (returns at least 1 so index fields never vanish).
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_n_stream_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker. The scan starts at last+1 and wraps
// modulo N; the first set bit of req wins.
//   req   [N]    request vector
//   last  [SELW] most recently granted index (highest priority goes to last+1)
//   idx   [SELW] winning index (0 when nothing is requested)
//   found        a request was found
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] idx,
  output logic            found
);

  int pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last) + k) % N;
      // Inner loop keeps every bit-select on a constant index.
      for (int i = 0; i < N; i++) begin
        if (!found && (pos == i) && req[i]) begin
          found = 1'b1;
          idx   = SELW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mux_n_stream.sv
// -----------------------------------------------------------------------------
// mux_n_stream
// N-input, WIDTH-bit stream multiplexer with a registered output stage.
// Arbitration is either fixed (channel given by sel) or round-robin.
//
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both high. Valid never depends on ready; in_ready may depend
// on in_valid. The output word stays stable while out_valid & !out_ready.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data  [N*WIDTH]    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid [N]          channel i offers a word
//   in_ready [N]          channel i word taken this cycle (at most one bit set)
//   mode                  MODE_FIXED uses sel, MODE_RR rotates
//   sel      [SELW]       channel index in MODE_FIXED
//   out_data [WIDTH]      registered word
//   out_chan [SELW]       source channel of out_data
//   out_valid             output holds a word
//   out_ready             consumer accepts the word
// -----------------------------------------------------------------------------
module mux_n_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // sel can address 2**SELW channels; padding in_valid to that size lets
  // sel index it directly, and the range check rejects the padded slots.
  localparam int NPAD = 1 << SELW;

  logic [NPAD-1:0]  valid_pad;
  logic             sel_in_range;
  logic [SELW-1:0]  rr_idx;
  logic             rr_found;
  logic [SELW-1:0]  grant;
  logic             gvalid;
  logic [WIDTH-1:0] gdata;
  logic             load_en;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic [SELW-1:0]  last_grant_q, last_grant_d;

  assign valid_pad    = NPAD'(in_valid);
  assign sel_in_range = ({1'b0, sel} < (SELW + 1)'(N));

  // Output register can take a new word when empty or being drained now.
  assign load_en = !out_valid_q | out_ready;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_pick (
    .req   (in_valid),
    .last  (last_grant_q),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // Grant selection per mode.
  always_comb begin
    grant  = '0;
    gvalid = 1'b0;
    unique case (mode)
      MODE_FIXED: begin
        grant  = sel;
        gvalid = sel_in_range & valid_pad[sel];
      end
      MODE_RR: begin
        grant  = rr_idx;
        gvalid = rr_found;
      end
      default: begin
        grant  = '0;
        gvalid = 1'b0;
      end
    endcase
  end

  // Data of the granted channel.
  always_comb begin
    gdata = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load_en & gvalid & (grant == SELW'(i));
    end
  end

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    last_grant_d = last_grant_q;
    if (load_en && gvalid) begin
      out_valid_d  = 1'b1;
      out_data_d   = gdata;
      out_chan_d   = grant;
      // Tracked in fixed mode too, so a switch to RR continues after it.
      last_grant_d = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      last_grant_q <= SELW'(N - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_n_stream.sv
// -----------------------------------------------------------------------------
// tb_mux_n_stream
// Bench for mux_n_stream (WIDTH=8, N=4) plus a small N=3 instance for the
// out-of-range select case. Inputs change 1 time unit after the rising edge.
// The reference model runs on the falling edge and pushes each word it
// expects to be loaded; the monitor runs 3 units after the rising edge and
// compares whatever the output register holds against the queue head.
// -----------------------------------------------------------------------------
module tb_mux_n_stream;
  import mux_pkg::*;

  localparam int W  = 8;
  localparam int NC = 4;
  localparam int SW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic [NC*W-1:0] in_data;
  logic [NC-1:0]   in_valid;
  logic [NC-1:0]   in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  mux_n_stream #(.WIDTH(W), .N(NC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- N=3 DUT for out-of-range select ----------------
  logic [3*W-1:0] e_in_data;
  logic [2:0]     e_in_valid;
  logic [2:0]     e_in_ready;
  logic           e_mode;
  logic [1:0]     e_sel;
  logic [W-1:0]   e_out_data;
  logic [1:0]     e_out_chan;
  logic           e_out_valid;
  logic           e_out_ready;

  mux_n_stream #(.WIDTH(W), .N(3)) dut_n3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (e_in_data),
    .in_valid  (e_in_valid),
    .in_ready  (e_in_ready),
    .mode      (e_mode),
    .sel       (e_sel),
    .out_data  (e_out_data),
    .out_chan  (e_out_chan),
    .out_valid (e_out_valid),
    .out_ready (e_out_ready)
  );

  // ---------------- scoreboard ----------------
  logic [SW+W-1:0] exp_q[$];
  int              log_q[$];
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // seq holds the expected channel order, element i in nibble i.
  task automatic check_log(input string name, input int n, input logic [63:0] seq);
    int got;
    chk({name, " count"}, 64'(log_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < log_q.size()) ? log_q[i] : -1;
      chk(name, 64'(got), (seq >> (4 * i)) & 64'hf);
    end
  endtask

  // ---------------- reference model ----------------
  // Describes the block in transfer terms: the output slot is free when empty
  // or being popped; the winning channel is sel (if valid) or the next valid
  // channel after the previous winner, counting cyclically.
  bit m_valid;
  int m_last;

  always @(negedge clk) begin
    bit            free_slot, have;
    int            win, c;
    logic [NC-1:0] exp_ready;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_last  = NC - 1;
    end else begin
      free_slot = !m_valid || out_ready;
      have = 1'b0;
      win  = 0;
      if (mode == MODE_FIXED) begin
        if (int'(sel) < NC && ((in_valid >> sel) & 1) == 1) begin
          have = 1'b1;
          win  = int'(sel);
        end
      end else begin
        for (int k = 1; k <= NC; k++) begin
          c = (m_last + k) % NC;
          if (!have && ((in_valid >> c) & 1) == 1) begin
            have = 1'b1;
            win  = c;
          end
        end
      end
      exp_ready = (free_slot && have) ? NC'(1 << win) : '0;
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      if (free_slot && have) begin
        exp_q.push_back({SW'(win), in_data[win*W +: W]});
        m_last  = win;
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rst_n) begin
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (out_valid && exp_q.size() != 0) begin
          chk("out_chan_data", 64'({out_chan, out_data}), 64'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            log_q.push_back(int'(out_chan));
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = '0;
    mode        = MODE_FIXED;
    sel         = '0;
    out_ready   = 1'b0;
    e_in_data   = {8'h33, 8'h22, 8'h11};
    e_in_valid  = 3'b111;
    e_mode      = MODE_FIXED;
    e_sel       = 2'b11;
    e_out_ready = 1'b1;

    // Reset state
    cyc(2);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst out_chan", 64'(out_chan), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;

    // Fixed sweep
    in_data   = 32'h44332211;
    in_valid  = 4'hf;
    out_ready = 1'b1;
    log_q.delete();
    for (int s = 0; s < NC; s++) begin
      sel = SW'(s);
      cyc(1);
    end
    in_valid = '0;
    cyc(2);
    check_log("fixed order", 4, 64'h3210);

    // Back-pressure: word from channel 1 held while sel/data churn
    log_q.delete();
    sel      = 2'd1;
    in_valid = 4'hf;
    cyc(1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel     = SW'($urandom_range(0, NC - 1));
      in_data = $urandom;
      cyc(1);
    end
    out_ready = 1'b1;
    sel       = 2'd3;
    cyc(1);
    in_valid = '0;
    cyc(2);
    check_log("backpressure order", 2, 64'h31);

    // Asynchronous reset while a word is held
    mode      = MODE_FIXED;
    sel       = 2'd2;
    in_data   = 32'h44332211;
    in_valid  = 4'hf;
    out_ready = 1'b0;
    cyc(2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async out_data", 64'(out_data), 64'd0);
    chk("async out_chan", 64'(out_chan), 64'd0);
    exp_q.delete();
    log_q.delete();
    in_valid = '0;
    cyc(2);

    // Round-robin fairness directly after reset release
    rst_n     = 1'b1;
    mode      = MODE_RR;
    in_data   = $urandom;
    in_valid  = 4'hf;
    out_ready = 1'b1;
    log_q.delete();
    cyc(8);
    in_valid = 4'b1101;
    cyc(4);
    in_valid = '0;
    cyc(2);
    check_log("rr order", 12, 64'h032032103210);

    // Sparse RR: lone requester, then channel 0 joins after the wrap
    log_q.delete();
    in_valid = 4'b1000;
    cyc(3);
    in_valid = 4'b1001;
    cyc(1);
    in_valid = '0;
    cyc(2);
    check_log("sparse order", 4, 64'h0333);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      mode      = $urandom_range(0, 1) == 1 ? MODE_RR : MODE_FIXED;
      sel       = SW'($urandom_range(0, NC - 1));
      in_valid  = NC'($urandom_range(0, (1 << NC) - 1));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    in_valid  = '0;
    out_ready = 1'b1;
    cyc(3);
    chk("drained", 64'(exp_q.size()), 64'd0);

    // N=3, sel=3: nothing may be granted
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      #2;
      chk("n3 in_ready", 64'(e_in_ready), 64'd0);
      chk("n3 out_valid", 64'(e_out_valid), 64'd0);
    end
    e_sel = 2'd2;
    @(posedge clk);
    #2;
    chk("n3 sel2 valid", 64'(e_out_valid), 64'd1);
    chk("n3 sel2 chan", 64'(e_out_chan), 64'd2);
    chk("n3 sel2 data", 64'(e_out_data), 64'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
